// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port between two
// requesters, granting whole transactions and flagging long downstream waits.
//
// Ports:
//   clk, reset                     sole clock, synchronous active-high reset
//   m0_* / m1_*                    requester native-memory ports
//                                  (valid/instr/addr/wdata/wstrb in,
//                                  ready/rdata out)
//   mem_*                          shared downstream native-memory port
//   busy                           a transaction is granted and in flight
//   grant_id                       current (or last) owner index
//   timeout                        sticky: a transaction waited too long
module picorv32_mem_arbiter #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        grant_id,
    output logic        timeout
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    localparam int unsigned CW =
        (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;

    logic            own_valid;
    logic            sel_m1;

    assign busy      = (state_q == S_BUSY);
    assign own_valid = owner_q ? m1_valid : m0_valid;

    // In IDLE the downstream fields follow m0 so they stay deterministic.
    assign sel_m1    = busy && owner_q;

    assign mem_valid = busy && own_valid;
    assign mem_instr = sel_m1 ? m1_instr : m0_instr;
    assign mem_addr  = sel_m1 ? m1_addr  : m0_addr;
    assign mem_wdata = sel_m1 ? m1_wdata : m0_wdata;
    assign mem_wstrb = sel_m1 ? m1_wstrb : m0_wstrb;

    // A reset in the completing cycle aborts the transfer, so no ready leaks.
    assign m0_ready  = mem_valid && mem_ready && !owner_q && !reset;
    assign m1_ready  = mem_valid && mem_ready &&  owner_q && !reset;

    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

    assign grant_id  = owner_q;
    assign timeout   = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        wait_cnt_d = '0;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d = S_BUSY;
                    if (m0_valid && m1_valid) begin
                        owner_d = ~last_q;
                    end else begin
                        owner_d = m1_valid;
                    end
                end
            end
            S_BUSY: begin
                if (!own_valid) begin
                    // Owner withdrew early: release the port, no ready.
                    state_d = S_IDLE;
                end else if (mem_ready) begin
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end else begin
                    if (wait_cnt_q != MAX_CNT) begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                    if ((MAX_WAIT != 0) && (wait_cnt_q == MAX_CNT)) begin
                        timeout_d = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule
